// File: rtl/bch_error_one_ctrl.sv
// Control FSM for single-error BCH correction: hands the locator to the search
// datapath, re-times and masks its per-beat error flags, and judges the outcome.
module bch_error_one_ctrl #(
  parameter int M               = 4,
  parameter int DATA_BITS       = 5,
  parameter int BITS            = 1,
  parameter int PIPELINE_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*M-1:0]    in_sigma,
  input  logic [1:0]        in_nerr,
  output logic              srch_start,
  output logic [2*M-1:0]    srch_sigma,
  input  logic              srch_first,
  input  logic [BITS-1:0]   srch_err,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [BITS-1:0]   out_err,
  output logic              done,
  output logic              fail
);

  localparam int NBEATS     = (DATA_BITS + BITS - 1) / BITS;
  localparam int BCNT_W     = $clog2(NBEATS + 1);
  localparam int LAT        = 2 + PIPELINE_STAGES;
  localparam int WCNT_W     = $clog2(LAT + 3);
  localparam int LAST_VALID = DATA_BITS - (NBEATS - 1) * BITS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic                rdy_q;
  logic [2*M-1:0]      sigma_q, sigma_d;
  logic [1:0]          nerr_q, nerr_d;
  logic                start_q, start_d;
  logic                ov_q, ov_d;
  logic                of_q, of_d;
  logic                ol_q, ol_d;
  logic [BITS-1:0]     oerr_q, oerr_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [1:0]          hits_q, hits_d;

  logic                accept;
  logic                take_beat;
  logic                last_beat;
  logic                timeout;
  logic [BCNT_W-1:0]   beat_idx;
  logic [BITS-1:0]     err_m;
  logic [1:0]          hits_sum;
  int                  pop;

  assign in_ready   = (state_q == S_IDLE) && rdy_q;
  assign accept     = in_ready && in_valid;
  assign take_beat  = ((state_q == S_WAIT) && srch_first) || (state_q == S_RUN);
  assign beat_idx   = (state_q == S_RUN) ? beat_q : '0;
  assign last_beat  = take_beat && (beat_idx == BCNT_W'(NBEATS - 1));
  assign timeout    = (state_q == S_WAIT) && !srch_first && (wait_q == WCNT_W'(LAT + 1));

  // Zero-error jobs suppress all flags; the final beat drops padding bits past DATA_BITS.
  always_comb begin
    err_m    = '0;
    pop      = 0;
    hits_sum = hits_q;
    for (int b = 0; b < BITS; b++) begin
      if ((nerr_q != 2'd0) && (!last_beat || (b < LAST_VALID))) err_m[b] = srch_err[b];
    end
    for (int b = 0; b < BITS; b++) pop = pop + int'(err_m[b]);
    if (int'(hits_q) + pop >= 2) hits_sum = 2'd2;
    else                         hits_sum = 2'(int'(hits_q) + pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (in_nerr >= 2'd2) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (srch_first)   state_d = last_beat ? S_DONE : S_RUN;
        else if (timeout) state_d = S_DONE;
      end
      S_RUN:  if (last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sigma_d = accept ? in_sigma : sigma_q;
    nerr_d  = accept ? in_nerr : nerr_q;
    start_d = accept && (in_nerr < 2'd2);
    ov_d    = take_beat;
    of_d    = take_beat && (state_q == S_WAIT);
    ol_d    = last_beat;
    oerr_d  = take_beat ? err_m : '0;
    beat_d  = beat_q;
    wait_d  = wait_q;
    hits_d  = hits_q;
    if (accept) begin
      beat_d = '0;
      wait_d = '0;
      hits_d = '0;
    end else begin
      if (take_beat)          beat_d = beat_idx + BCNT_W'(1);
      if (take_beat)          hits_d = hits_sum;
      if (state_q == S_WAIT)  wait_d = wait_q + WCNT_W'(1);
    end
    done_d = (state_d == S_DONE);
    fail_d = done_d && ((state_q == S_IDLE) || timeout ||
                        ((nerr_q == 2'd1) && (hits_sum != 2'd1)));
  end

  // rdy_q holds off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      sigma_q <= '0;
      nerr_q  <= '0;
      start_q <= 1'b0;
      ov_q    <= 1'b0;
      of_q    <= 1'b0;
      ol_q    <= 1'b0;
      oerr_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
      hits_q  <= '0;
    end else begin
      rdy_q   <= 1'b1;
      sigma_q <= sigma_d;
      nerr_q  <= nerr_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      of_q    <= of_d;
      ol_q    <= ol_d;
      oerr_q  <= oerr_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      hits_q  <= hits_d;
    end
  end

  assign srch_start = start_q;
  assign srch_sigma = sigma_q;
  assign out_valid  = ov_q;
  assign out_first  = of_q;
  assign out_last   = ol_q;
  assign out_err    = oerr_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_bch_error_one_ctrl.sv
// Bench for bch_error_one_ctrl: one 1-bit-per-beat and one 2-bit-per-beat instance
// driven by the same jobs, checked cycle by cycle against a codeword-level model.
module tb_bch_error_one_ctrl;
  localparam int M  = 4;
  localparam int DB = 5;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic [2*M-1:0] in_sigma = '0;
  logic [1:0]     in_nerr = '0;
  logic           srch_first = 1'b0;
  logic [0:0]     srch_err1 = '0;
  logic [1:0]     srch_err2 = '0;

  logic           in_ready_a, srch_start_a, out_valid_a, out_first_a, out_last_a, done_a, fail_a;
  logic [2*M-1:0] srch_sigma_a;
  logic [0:0]     out_err_a;
  logic           in_ready_b, srch_start_b, out_valid_b, out_first_b, out_last_b, done_b, fail_b;
  logic [2*M-1:0] srch_sigma_b;
  logic [1:0]     out_err_b;

  bch_error_one_ctrl #(.M(M), .DATA_BITS(DB), .BITS(1), .PIPELINE_STAGES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sigma(in_sigma), .in_nerr(in_nerr), .srch_start(srch_start_a),
    .srch_sigma(srch_sigma_a), .srch_first(srch_first), .srch_err(srch_err1),
    .out_valid(out_valid_a), .out_first(out_first_a), .out_last(out_last_a),
    .out_err(out_err_a), .done(done_a), .fail(fail_a));

  bch_error_one_ctrl #(.M(M), .DATA_BITS(DB), .BITS(2), .PIPELINE_STAGES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sigma(in_sigma), .in_nerr(in_nerr), .srch_start(srch_start_b),
    .srch_sigma(srch_sigma_b), .srch_first(srch_first), .srch_err(srch_err2),
    .out_valid(out_valid_b), .out_first(out_first_b), .out_last(out_last_b),
    .out_err(out_err_b), .done(done_b), .fail(fail_b));

  typedef struct {
    logic [1:0] nerr;
    int         d;       // WAIT cycles before srch_first; beyond L+1 means never
    logic [4:0] e1;      // bit j = flag of beat j for the 1-bit instance
    logic [5:0] e2;      // bits [2j+1:2j] = beat j for the 2-bit instance
    logic [7:0] sigma;
    logic       fail1;
    logic       fail2;
  } job_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Codeword-level verdict: which data bits the solver's single error could be.
  function automatic logic model_fail(input job_t j, input logic [DB-1:0] bits);
    if (j.nerr >= 2'd2 || j.d > L + 1) return 1'b1;
    return (j.nerr == 2'd1) && ($countones(bits) != 1);
  endfunction

  task automatic run_job(input job_t j);
    int w, k, jb, done1, done2, last_c;
    logic run;
    logic [5:0] m2;
    w = 0;
    while (!(in_ready_a && in_ready_b) && w < 30) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_job", 32'(in_ready_a && in_ready_b), 32'd1);
    run = (j.nerr < 2'd2) && (j.d <= L + 1);
    m2  = (j.nerr == 2'd0) ? 6'd0 : {1'b0, j.e2[4:0]};
    if (j.nerr >= 2'd2) begin done1 = 1; done2 = 1; end
    else if (!run)      begin done1 = L + 3; done2 = L + 3; end
    else                begin done1 = 2 + j.d + 4; done2 = 2 + j.d + 2; end
    last_c = ((done1 > done2) ? done1 : done2) + 1;
    in_valid = 1'b1; in_sigma = j.sigma; in_nerr = j.nerr;
    srch_first = 1'b0; srch_err1 = 1'($urandom); srch_err2 = 2'($urandom);
    @(posedge clk); #1;
    for (int c = 1; c <= last_c; c++) begin
      in_valid   = (c == 1);
      in_sigma   = 8'($urandom);
      in_nerr    = 2'($urandom);
      srch_first = run && (c == 1 + j.d);
      k = c - 1 - j.d;
      srch_err1 = (run && k >= 0 && k < 5) ? j.e1[k]       : 1'($urandom);
      srch_err2 = (run && k >= 0 && k < 3) ? j.e2[2*k +: 2] : 2'($urandom);
      @(negedge clk);
      jb = c - 2 - j.d;
      chk("srch_start_a", 32'(srch_start_a), 32'(c == 1 && j.nerr < 2'd2));
      chk("srch_start_b", 32'(srch_start_b), 32'(c == 1 && j.nerr < 2'd2));
      chk("srch_sigma_a", 32'(srch_sigma_a), 32'(j.sigma));
      chk("srch_sigma_b", 32'(srch_sigma_b), 32'(j.sigma));
      chk("done_a", 32'(done_a), 32'(c == done1));
      chk("done_b", 32'(done_b), 32'(c == done2));
      chk("fail_a", 32'(fail_a), 32'(c == done1 && j.fail1));
      chk("fail_b", 32'(fail_b), 32'(c == done2 && j.fail2));
      chk("in_ready_a", 32'(in_ready_a), 32'(c > done1));
      chk("in_ready_b", 32'(in_ready_b), 32'(c > done2));
      chk("out_valid_a", 32'(out_valid_a), 32'(run && jb >= 0 && jb < 5));
      chk("out_valid_b", 32'(out_valid_b), 32'(run && jb >= 0 && jb < 3));
      if (run && jb >= 0 && jb < 5) begin
        chk("out_first_a", 32'(out_first_a), 32'(jb == 0));
        chk("out_last_a",  32'(out_last_a),  32'(jb == 4));
        chk("out_err_a",   32'(out_err_a),   32'((j.nerr == 2'd0) ? 1'b0 : j.e1[jb]));
      end
      if (run && jb >= 0 && jb < 3) begin
        chk("out_first_b", 32'(out_first_b), 32'(jb == 0));
        chk("out_last_b",  32'(out_last_b),  32'(jb == 2));
        chk("out_err_b",   32'(out_err_b),   32'(m2[2*jb +: 2]));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; srch_first = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"},  32'(out_valid_a | out_valid_b), 32'd0);
    chk({tag, "_out_first"},  32'(out_first_a | out_first_b), 32'd0);
    chk({tag, "_out_last"},   32'(out_last_a | out_last_b), 32'd0);
    chk({tag, "_out_err"},    32'({out_err_a, out_err_b}), 32'd0);
    chk({tag, "_done"},       32'(done_a | done_b), 32'd0);
    chk({tag, "_fail"},       32'(fail_a | fail_b), 32'd0);
    chk({tag, "_srch_start"}, 32'(srch_start_a | srch_start_b), 32'd0);
    chk({tag, "_srch_sigma"}, 32'({srch_sigma_a, srch_sigma_b}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  job_t tbl [9];
  job_t rj;

  initial begin
    //        nerr  d  e1         e2           sigma  fail1 fail2
    tbl[0] = '{2'd1, 2, 5'b01000, 6'b111111, 8'h3C, 1'b0, 1'b1};
    tbl[1] = '{2'd2, 0, 5'b00000, 6'b000000, 8'h81, 1'b1, 1'b1};
    tbl[2] = '{2'd0, 1, 5'b11111, 6'b111111, 8'h5A, 1'b0, 1'b0};
    tbl[3] = '{2'd1, 7, 5'b00100, 6'b000100, 8'hC3, 1'b1, 1'b1};
    tbl[4] = '{2'd1, 3, 5'b00001, 6'b100000, 8'h17, 1'b0, 1'b1};
    tbl[5] = '{2'd1, 0, 5'b00000, 6'b000100, 8'hE4, 1'b1, 1'b0};
    tbl[6] = '{2'd3, 1, 5'b00010, 6'b000010, 8'h99, 1'b1, 1'b1};
    tbl[7] = '{2'd1, 1, 5'b10000, 6'b010000, 8'h42, 1'b0, 1'b0};
    tbl[8] = '{2'd1, 2, 5'b00011, 6'b000011, 8'h6D, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(in_ready_a && in_ready_b), 32'd1);

    for (int i = 0; i < 9; i++) run_job(tbl[i]);

    // Abort in the middle of a codeword, then a normal job must follow.
    in_valid = 1'b1; in_sigma = 8'hA5; in_nerr = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; srch_first = 1'b1; srch_err1 = 1'b1; srch_err2 = 2'b01;
    @(posedge clk); #1;
    srch_first = 1'b0; srch_err1 = 1'b0; srch_err2 = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_valid_before_reset", 32'(out_valid_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrun_no_done", 32'(done_a | done_b | out_valid_a | out_valid_b), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_no_done", 32'(done_a | done_b), 32'd0);
    @(posedge clk); #1;
    run_job(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      rj.nerr  = (r == 0) ? 2'd0 : (r == 6) ? 2'd2 : (r == 7) ? 2'd3 : 2'd1;
      rj.d     = int'($urandom_range(0, 5));
      rj.sigma = 8'($urandom);
      for (int b = 0; b < 5; b++) rj.e1[b] = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 6; b++) rj.e2[b] = ($urandom_range(0, 3) == 0);
      rj.fail1 = model_fail(rj, rj.e1);
      rj.fail2 = model_fail(rj, rj.e2[4:0]);
      run_job(rj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bch_error_one_ctrl.md
BCH_ERROR_ONE_CTRL -- requirements
Module: bch_error_one_ctrl

Interface
REQ-001 Param M, default 4: Galois field order; sigma coefficient width.
REQ-002 Param DATA_BITS, default 5: data bits per codeword to search (≥1).
REQ-003 Param BITS, default 1: error-search bits produced per beat (1..DATA_BITS).
REQ-004 Param PIPELINE_STAGES, default 0: search datapath output pipeline depth (0 or 1); search latency L = 2 + PIPELINE_STAGES cycles.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  job offered.
REQ-008 in_ready  out  1  controller idle, accepts job.
REQ-009 in_sigma  in  2*M  error locator coefficients from solver.
REQ-010 in_nerr  in  2  error count claimed by solver (0, 1, ≥2 encoded as 2/3).
REQ-011 srch_start  out  1  one-cycle start strobe to single-error search datapath.
REQ-012 srch_sigma  out  2*M  registered sigma driven to datapath.
REQ-013 srch_first  in  1  datapath first-valid-beat strobe.
REQ-014 srch_err  in  BITS  datapath per-beat error flags.
REQ-015 out_valid  out  1  out_err beat valid.
REQ-016 out_first  out  1  first beat of codeword.
REQ-017 out_last  out  1  last beat of codeword.
REQ-018 out_err  out  BITS  error flags, bit b = data bit (beat*BITS+b).
REQ-019 done  out  1  one-cycle job-complete strobe.
REQ-020 fail  out  1  uncorrectable flag, valid with done.

Function
REQ-021 States IDLE, WAIT, RUN, DONE; in_ready = 1 only in IDLE.
REQ-022 IDLE: in_valid=1 captures in_sigma, in_nerr; next state WAIT; srch_start=1 next cycle for exactly one cycle.
REQ-023 in_nerr=0: srch_start still issued; all out_err beats forced to zero regardless of srch_err.
REQ-024 in_nerr≥2: no srch_start; state goes directly to DONE; done=1, fail=1; no out_valid beats.
REQ-025 WAIT: leave for RUN on srch_first=1; WAIT counter exceeding L+1 cycles without srch_first goes to DONE with fail=1.
REQ-026 RUN: NBEATS = ceil(DATA_BITS/BITS) consecutive out_valid beats, no bubbles, beat 0 coincident with srch_first; out_first on beat 0, out_last on beat NBEATS-1 (both on same beat when NBEATS=1).
REQ-027 Last beat: bits with index ≥ DATA_BITS masked to zero.
REQ-028 Hit counter saturates at 2; counts masked out_err bits set across codeword.
REQ-029 DONE one cycle: done=1; fail=1 if in_nerr=1 and hits≠1, else fail=0; then IDLE.
REQ-030 Outputs registered; out_err lags srch_err by one cycle; out_valid/out_first/out_last aligned with out_err.
REQ-031 Beat counter width clog2(NBEATS+1); no wrap within a job.
REQ-032 in_valid while not IDLE ignored; input data not captured.
REQ-033 srch_sigma holds captured value from capture until next accepted job.
REQ-034 fail=0 whenever done=0.

Reset
REQ-035 rst_n=0 immediately: state IDLE, in_ready=1 after deassert; srch_start, out_valid, out_first, out_last, done, fail = 0; out_err, srch_sigma, counters = 0.
REQ-036 Reset mid-RUN aborts job; no done pulse; first cycle after deassert is IDLE.
REQ-037 Deassertion synchronous to clk; first job accepted on second edge after deassert.

Verification
REQ-038 M=4, DATA_BITS=5, BITS=1, in_nerr=1, srch_first 2 cycles after start, srch_err=1 on beat 3 only -> 5 beats, out_err=1 on beat 3, done=1, fail=0.
REQ-039 BITS=2, DATA_BITS=5, srch_err=2'b11 every beat -> 3 beats, last beat out_err=2'b01, hits saturate, done with fail=1.
REQ-040 in_nerr=2 -> no srch_start, no out_valid, done=1, fail=1 one cycle after accept.
REQ-041 in_nerr=0, srch_err nonzero -> all out_err zero, done=1, fail=0.
REQ-042 srch_first never asserted -> done=1, fail=1 after L+2 cycles in WAIT; in_ready returns.
REQ-043 rst_n low during RUN beat 2 -> outputs zero immediately, no done, next job processed normally.
